// File: rtl/bcam_upd_ctrl.sv
// bcam_upd_ctrl: insert/delete update controller in front of a bcam.
// A request is looked up through the CAM match port. Depending on the result,
// an address is allocated or freed and written through the CAM write port.
// One response pulse per request reports a status code and the address involved.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; the accept edge registers op/pattern
// LOOK  | waiting MLAT cycles for camMatch/camMAddr to settle
// WRITE | single-cycle camWEnb; bitmap and count update on this edge
// WAIT  | WLAT cycles so the next lookup sees the written entry
// RESP  | one-cycle rspValid pulse, then back to IDLE
module bcam_upd_ctrl #(
  parameter int              CAMD = 256,
  parameter int              CAMW = 32,
  parameter int              MLAT = 2,
  parameter int              WLAT = 2,
  parameter logic [CAMW-1:0] DELP = {CAMW{1'b1}},
  localparam int             AW   = $clog2(CAMD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reqValid,
  output logic            reqReady,
  input  logic            reqOp,
  input  logic [CAMW-1:0] reqPatt,
  output logic            rspValid,
  output logic [2:0]      rspStat,
  output logic [AW-1:0]   rspAddr,
  output logic            camWEnb,
  output logic [AW-1:0]   camWAddr,
  output logic [CAMW-1:0] camWPatt,
  output logic [CAMW-1:0] camMPatt,
  input  logic            camMatch,
  input  logic [AW-1:0]   camMAddr,
  output logic [AW:0]     count
);

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_DUP      = 3'd1;
  localparam logic [2:0] ST_FULL     = 3'd2;
  localparam logic [2:0] ST_NOTFOUND = 3'd3;
  localparam logic [2:0] ST_RSVD     = 3'd4;

  localparam logic [2:0]  MLAT_LOAD = 3'(MLAT - 1);
  localparam logic [2:0]  WLAT_LOAD = 3'(WLAT - 1);
  localparam logic [AW:0] CNT_FULL  = (AW+1)'(CAMD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOOK  = 3'd1,
    S_WRITE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            op_q, op_d;
  logic [CAMW-1:0] patt_q, patt_d;
  logic [2:0]      tmr_q, tmr_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [CAMW-1:0] wpatt_q, wpatt_d;
  logic [2:0]      stat_q, stat_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic [CAMD-1:0] vld_q, vld_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   free_idx;

  // Lowest-index clear bit of the occupancy bitmap; only used when not full.
  always_comb begin
    free_idx = '0;
    for (int i = CAMD - 1; i >= 0; i--) begin
      if (!vld_q[i]) free_idx = AW'(i);
    end
  end

  // State register and datapath registers; reset aborts any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      patt_q  <= '0;
      tmr_q   <= '0;
      waddr_q <= '0;
      wpatt_q <= '0;
      stat_q  <= '0;
      raddr_q <= '0;
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      patt_q  <= patt_d;
      tmr_q   <= tmr_d;
      waddr_q <= waddr_d;
      wpatt_q <= wpatt_d;
      stat_q  <= stat_d;
      raddr_q <= raddr_d;
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: accept, lookup decision, write bookkeeping, response.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    patt_d  = patt_q;
    tmr_d   = tmr_q;
    waddr_d = waddr_q;
    wpatt_d = wpatt_q;
    stat_d  = stat_q;
    raddr_d = raddr_q;
    vld_d   = vld_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (reqValid) begin
          op_d   = reqOp;
          patt_d = reqPatt;
          if (reqPatt == DELP) begin
            stat_d  = ST_RSVD;
            raddr_d = '0;
            state_d = S_RESP;
          end else begin
            tmr_d   = MLAT_LOAD;
            state_d = S_LOOK;
          end
        end
      end
      S_LOOK: begin
        if (tmr_q != 3'd0) begin
          tmr_d = tmr_q - 3'd1;
        end else if (!op_q) begin
          if (camMatch) begin
            stat_d  = ST_DUP;
            raddr_d = camMAddr;
            state_d = S_RESP;
          end else if (count_q == CNT_FULL) begin
            stat_d  = ST_FULL;
            raddr_d = '0;
            state_d = S_RESP;
          end else begin
            waddr_d = free_idx;
            wpatt_d = patt_q;
            state_d = S_WRITE;
          end
        end else begin
          if (camMatch) begin
            waddr_d = camMAddr;
            wpatt_d = DELP;
            state_d = S_WRITE;
          end else begin
            stat_d  = ST_NOTFOUND;
            raddr_d = '0;
            state_d = S_RESP;
          end
        end
      end
      S_WRITE: begin
        if (!op_q) begin
          vld_d[waddr_q] = 1'b1;
          count_d        = count_q + 1'b1;
        end else begin
          vld_d[waddr_q] = 1'b0;
          // Guarded so a bitmap/CAM disagreement can never underflow count.
          if (vld_q[waddr_q]) count_d = count_q - 1'b1;
        end
        tmr_d   = WLAT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tmr_q != 3'd0) begin
          tmr_d = tmr_q - 3'd1;
        end else begin
          stat_d  = ST_OK;
          raddr_d = waddr_q;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are masked during reset so an aborted request never writes.
  assign reqReady = (state_q == S_IDLE)  && !rst;
  assign rspValid = (state_q == S_RESP)  && !rst;
  assign camWEnb  = (state_q == S_WRITE) && !rst;
  assign rspStat  = stat_q;
  assign rspAddr  = raddr_q;
  assign camWAddr = waddr_q;
  assign camWPatt = wpatt_q;
  assign camMPatt = patt_q;
  assign count    = count_q;

endmodule

// File: doc/bcam_upd_ctrl.md
Name: bcam_upd_ctrl

Overview:
Upstream update controller for the bcam block. It accepts insert/delete requests for patterns over a valid/ready handshake. For each request it performs a duplicate/existence lookup through the CAM match port, then allocates or frees an address and issues a single-cycle write on the CAM write port. It tracks occupancy and reports a one-cycle response with a status code and the address involved.

Parameters:
CAMD, 256, CAM depth; must equal the attached bcam CAMD
CAMW, 32, pattern width; must equal the attached bcam CAMW
MLAT, 2, cycles from camMPatt change to a valid camMatch/camMAddr; must equal the attached bcam match latency, range 1..4
WLAT, 2, cycles after a camWEnb cycle before the written entry is visible to a match, range 1..4
DELP, {CAMW{1'b1}}, reserved "erased" pattern written on delete; never accepted as a request pattern

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high; shared with the attached bcam rst
reqValid  in  1  request valid
reqReady  out  1  controller can accept a request
reqOp  in  1  0 = insert, 1 = delete
reqPatt  in  CAMW  request pattern
rspValid  out  1  one-cycle response pulse
rspStat  out  3  0 OK, 1 DUP, 2 FULL, 3 NOTFOUND, 4 RSVD
rspAddr  out  log2(CAMD)  address written, found, or duplicated; 0 for FULL/RSVD
camWEnb  out  1  to bcam wEnb
camWAddr  out  log2(CAMD)  to bcam wAddr
camWPatt  out  CAMW  to bcam wPatt
camMPatt  out  CAMW  to bcam mPatt
camMatch  in  1  from bcam match
camMAddr  in  log2(CAMD)  from bcam mAddr
count  out  log2(CAMD)+1  number of occupied entries

Behaviour:
- Reset (synchronous, any state, aborts an in-flight request):
  - State goes to IDLE.
  - Valid bitmap (CAMD bits) and count are cleared.
  - All outputs are 0 except reqReady, which is 1 on the cycle after the reset cycle.
  - No camWEnb is issued for the aborted request.
- FSM states: IDLE, LOOK, WRITE, WAIT, RESP.
- IDLE:
  - reqReady = 1.
  - Accept on the edge where reqValid & reqReady; register reqOp and reqPatt. camMPatt is driven from the registered pattern.
  - If the pattern == DELP, go to RESP with RSVD; no lookup and no write.
  - Otherwise go to LOOK.
- LOOK:
  - Lasts exactly MLAT cycles, counted by a down-counter.
  - camMatch/camMAddr are sampled on the edge that ends the last LOOK cycle.
- Decision at the end of LOOK:
  - Insert, match: RESP, DUP, rspAddr = camMAddr. No write.
  - Insert, no match, count == CAMD: RESP, FULL, rspAddr = 0.
  - Insert, no match, not full: allocate the lowest-index clear bit of the valid bitmap (priority encoder). Go to WRITE with camWAddr = that index, camWPatt = pattern.
  - Delete, no match: RESP, NOTFOUND, rspAddr = 0.
  - Delete, match: go to WRITE with camWAddr = camMAddr, camWPatt = DELP.
- WRITE:
  - One cycle with camWEnb = 1; camWAddr/camWPatt are registered and stable.
  - Updates on the same edge: insert sets the bitmap bit and increments count; delete clears the bit and decrements count.
  - Then go to WAIT.
- WAIT: lasts WLAT cycles, so the next lookup sees the update. Then go to RESP with OK and rspAddr = the written address.
- RESP: rspValid = 1 for exactly one cycle, then IDLE. There is no backpressure on the response. rspStat/rspAddr are held until the next response.
- Latency (accept edge = cycle 0):
  - Write path: RESP at cycle MLAT+WLAT+2.
  - Non-write path: RESP at cycle MLAT+1.
  - RSVD: RESP at cycle 1.
  - With defaults: OK at 6, DUP/FULL/NOTFOUND at 3, next reqReady at 7/4.
- Only one request is in flight at a time. reqReady = 0 in every non-IDLE state; reqValid there is ignored and does not affect state.
- camWEnb = 0 in every state except WRITE. The controller never issues two writes for one request.
- count saturates by construction (0..CAMD): FULL blocks the increment, NOTFOUND blocks the decrement.
- Boundaries:
  - The last free slot is index CAMD-1 when all lower slots are used.
  - After a delete, the freed lowest index is reused by the next insert.

Test Plan:
- Reset, then insert 0x0000_00AA → rspValid at cycle 6, OK, rspAddr 0, count 1. camWEnb high exactly at cycle 3 with addr 0, patt 0xAA.
- Insert 0xAA again → rspValid at cycle 3, DUP, rspAddr 0, no camWEnb, count 1.
- Insert 0xB1, 0xB2; delete 0xB1; insert 0xC3 → 0xB1 gets addr 1, 0xB2 addr 2. The delete returns OK at addr 1 and writes DELP there. 0xC3 gets addr 1 (lowest free); final count 3.
- Delete 0x1234 (absent) → NOTFOUND, rspAddr 0, no write. Insert 0xFFFF_FFFF → RSVD at cycle 1, no lookup.
- Fill CAMD=8 instance with 8 unique patterns, then insert a 9th → FULL, count stays 8. Delete one, then the 9th insert → OK at the freed address.
- Assert rst during the WAIT of an insert, then re-insert the same pattern → no response for the aborted request, count 0. The re-insert returns OK at addr 0 (the CAM was reset together with the controller).
